// File: rtl/st7735_spi_sink.sv
// st7735_spi_sink: display-side receiver for the ST7735 4-wire SPI link.
// Oversamples SCE/RST/D_C/MOSI/SCLK in the clk_24mhz domain, deframes bytes and
// decodes CASET/RASET/RAMWR into RGB565 pixel writes with x/y coordinates.
// Optional feature macro: ST7735_SINK_STATS_EN adds saturating pixel/command counters.
`timescale 1ns/1ps
module st7735_spi_sink #(
  parameter int unsigned WIDTH       = 128,
  parameter int unsigned HEIGHT      = 160,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_24mhz,
  input  logic        rst_n,
  input  logic        SCE,
  input  logic        RST,
  input  logic        D_C,
  input  logic        MOSI,
  input  logic        SCLK,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_dc,
  output logic        pix_valid,
  output logic [7:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        frame_err
`ifdef ST7735_SINK_STATS_EN
  ,
  output logic [23:0] stat_pix_cnt,
  output logic [15:0] stat_cmd_cnt
`endif
);

  localparam logic [7:0] XE_DEF = 8'(WIDTH - 1);
  localparam logic [7:0] YE_DEF = 8'(HEIGHT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCasetArg,
    StRasetArg,
    StRamwr,
    StIgnore
  } state_t;

  // Synchronizer chain, bit order {SCE, RST, D_C, MOSI, SCLK}; idle levels SCE=1, RST=1
  logic [4:0] sync_q [SYNC_STAGES];
  logic       sce_s, rst_s, dc_s, mosi_s, sclk_s;

  assign sce_s  = sync_q[SYNC_STAGES-1][4];
  assign rst_s  = sync_q[SYNC_STAGES-1][3];
  assign dc_s   = sync_q[SYNC_STAGES-1][2];
  assign mosi_s = sync_q[SYNC_STAGES-1][1];
  assign sclk_s = sync_q[SYNC_STAGES-1][0];

  // Shift link inputs through SYNC_STAGES flops
  always_ff @(posedge clk_24mhz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= 5'b11000;
    end else begin
      sync_q[0] <= {SCE, RST, D_C, MOSI, SCLK};
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  logic       sclk_prev, sce_prev;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       done, done_dc;
  logic       hold;  // set by panel reset, released by the next SCE falling edge
  logic       sclk_rise, sce_fall, emit, partial_abort;

  assign sclk_rise     = sclk_s & ~sclk_prev;
  assign sce_fall      = sce_prev & ~sce_s;
  assign emit          = done & ~hold & rst_s;
  assign partial_abort = rst_s & ~hold & sce_s & (bit_cnt != 3'd0);

  // Deserializer: shift on SCLK rises, present the byte one cycle after the 8th rise
  always_ff @(posedge clk_24mhz or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev  <= 1'b0;
      sce_prev   <= 1'b1;
      bit_cnt    <= 3'd0;
      shift_reg  <= 8'd0;
      done       <= 1'b0;
      done_dc    <= 1'b0;
      hold       <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
      byte_dc    <= 1'b0;
    end else begin
      sclk_prev  <= sclk_s;
      sce_prev   <= sce_s;
      done       <= 1'b0;
      byte_valid <= emit;
      if (emit) begin
        byte_data <= shift_reg;
        byte_dc   <= done_dc;
      end
      if (!rst_s) begin
        hold    <= 1'b1;
        bit_cnt <= 3'd0;
      end else if (hold) begin
        bit_cnt <= 3'd0;
        if (sce_fall) hold <= 1'b0;
      end else if (sce_s) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        shift_reg <= {shift_reg[6:0], mosi_s};
        bit_cnt   <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          done    <= 1'b1;
          done_dc <= dc_s;
        end
      end
    end
  end

  state_t     state;
  logic [1:0] arg_idx;
  logic [7:0] arg_start;
  logic [7:0] xs, xe, ys, ye;
  logic [7:0] cur_x, cur_y;
  logic [7:0] pix_hi;
  logic       pix_odd;

  // Command decoder, window registers, RAMWR cursor and pixel output
  always_ff @(posedge clk_24mhz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      arg_idx   <= 2'd0;
      arg_start <= 8'd0;
      xs        <= 8'd0;
      xe        <= XE_DEF;
      ys        <= 8'd0;
      ye        <= YE_DEF;
      cur_x     <= 8'd0;
      cur_y     <= 8'd0;
      pix_hi    <= 8'd0;
      pix_odd   <= 1'b0;
      pix_valid <= 1'b0;
      pix_x     <= 8'd0;
      pix_y     <= 8'd0;
      pix_data  <= 16'd0;
      frame_err <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      if (partial_abort) frame_err <= 1'b1;
      if (!rst_s) begin
        state     <= StIdle;
        arg_idx   <= 2'd0;
        pix_odd   <= 1'b0;
        xs        <= 8'd0;
        xe        <= XE_DEF;
        ys        <= 8'd0;
        ye        <= YE_DEF;
        frame_err <= 1'b0;
      end else if (byte_valid) begin
        if (!byte_dc) begin
          // Any command aborts partial arguments and a dangling high byte
          arg_idx <= 2'd0;
          pix_odd <= 1'b0;
          case (byte_data)
            8'h2A: state <= StCasetArg;
            8'h2B: state <= StRasetArg;
            8'h2C: begin
              state <= StRamwr;
              cur_x <= xs;
              cur_y <= ys;
            end
            8'h01: begin
              state     <= StIdle;
              xs        <= 8'd0;
              xe        <= XE_DEF;
              ys        <= 8'd0;
              ye        <= YE_DEF;
              frame_err <= 1'b0;
            end
            default: state <= StIgnore;
          endcase
        end else begin
          case (state)
            StCasetArg, StRasetArg: begin
              arg_idx <= arg_idx + 2'd1;
              if (arg_idx == 2'd1) arg_start <= byte_data;
              if (arg_idx == 2'd3) begin
                state <= StIdle;
                if (state == StCasetArg) begin
                  xs <= arg_start;
                  xe <= byte_data;
                end else begin
                  ys <= arg_start;
                  ye <= byte_data;
                end
              end
            end
            StRamwr: begin
              if (!pix_odd) begin
                pix_hi  <= byte_data;
                pix_odd <= 1'b1;
              end else begin
                pix_odd   <= 1'b0;
                pix_valid <= 1'b1;
                pix_x     <= cur_x;
                pix_y     <= cur_y;
                pix_data  <= {pix_hi, byte_data};
                if (cur_x == xe) begin
                  cur_x <= xs;
                  cur_y <= (cur_y == ye) ? ys : cur_y + 8'd1;
                end else begin
                  cur_x <= cur_x + 8'd1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef ST7735_SINK_STATS_EN
  // Saturating activity counters, cleared only by rst_n
  always_ff @(posedge clk_24mhz or negedge rst_n) begin
    if (!rst_n) begin
      stat_pix_cnt <= 24'd0;
      stat_cmd_cnt <= 16'd0;
    end else begin
      if (pix_valid && stat_pix_cnt != 24'hFF_FFFF) stat_pix_cnt <= stat_pix_cnt + 24'd1;
      if (byte_valid && !byte_dc && stat_cmd_cnt != 16'hFFFF) begin
        stat_cmd_cnt <= stat_cmd_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_st7735_spi_sink.sv
// Scoreboard bench for st7735_spi_sink; uses a reduced 8x6 panel so full-window
// wrap fits in a short run. Build with +define+ST7735_SINK_STATS_EN for counters.
`timescale 1ns/1ps
module tb_st7735_spi_sink;
  localparam int W = 8;
  localparam int H = 6;

  logic        clk_24mhz = 1'b0;
  logic        rst_n, SCE, RST, D_C, MOSI, SCLK;
  logic        byte_valid, byte_dc, pix_valid, frame_err;
  logic [7:0]  byte_data, pix_x, pix_y;
  logic [15:0] pix_data;
`ifdef ST7735_SINK_STATS_EN
  logic [23:0] stat_pix_cnt;
  logic [15:0] stat_cmd_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [8:0]  exp_byte_q[$];
  logic [31:0] exp_pix_q[$];

  always #5 clk_24mhz = ~clk_24mhz;

  st7735_spi_sink #(
    .WIDTH(W),
    .HEIGHT(H),
    .SYNC_STAGES(2)
  ) dut (
    .clk_24mhz (clk_24mhz),
    .rst_n     (rst_n),
    .SCE       (SCE),
    .RST       (RST),
    .D_C       (D_C),
    .MOSI      (MOSI),
    .SCLK      (SCLK),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_dc   (byte_dc),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_data  (pix_data),
    .frame_err (frame_err)
`ifdef ST7735_SINK_STATS_EN
    ,
    .stat_pix_cnt(stat_pix_cnt),
    .stat_cmd_cnt(stat_cmd_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of its queue
  always @(negedge clk_24mhz) begin
    if (rst_n === 1'b1) begin
      if (byte_valid) begin
        if (exp_byte_q.size() == 0) check("unexpected_byte", {23'd0, byte_dc, byte_data}, 32'hFFFF_FFFF);
        else check("byte", {23'd0, byte_dc, byte_data}, {23'd0, exp_byte_q.pop_front()});
      end
      if (pix_valid) begin
        if (exp_pix_q.size() == 0) check("unexpected_pixel", {pix_x, pix_y, pix_data}, 32'hFFFF_FFFF);
        else check("pixel", {pix_x, pix_y, pix_data}, exp_pix_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_24mhz);
  endtask

  task automatic clock_bit(input logic b);
    MOSI = b;
    tick(4);
    SCLK = 1'b1;
    tick(4);
    SCLK = 1'b0;
  endtask

  task automatic send_bits(input logic dc, input logic [7:0] val, input int nbits);
    @(negedge clk_24mhz);
    SCE = 1'b0;
    D_C = dc;
    tick(4);
    for (int i = 0; i < nbits; i++) clock_bit(val[7-i]);
    tick(4);
    SCE = 1'b1;
    tick(4);
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] val);
    exp_byte_q.push_back({dc, val});
    send_bits(dc, val, 8);
  endtask

  task automatic cmd(input logic [7:0] v);
    send_byte(1'b0, v);
  endtask

  task automatic dat(input logic [7:0] v);
    send_byte(1'b1, v);
  endtask

  task automatic exp_pix(input int x, input int y, input logic [15:0] d);
    exp_pix_q.push_back({8'(x), 8'(y), d});
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && (exp_byte_q.size() + exp_pix_q.size()) > 0; i++) tick(1);
    check(name, exp_byte_q.size() + exp_pix_q.size(), 0);
    exp_byte_q.delete();
    exp_pix_q.delete();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_byte_valid"}, {31'd0, byte_valid}, 0);
    check({tag, "_byte_data"}, {24'd0, byte_data}, 0);
    check({tag, "_pix_valid"}, {31'd0, pix_valid}, 0);
    check({tag, "_pix_xy_data"}, {pix_x, pix_y, pix_data}, 0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 0);
  endtask

  task automatic pulse_rst_n();
    @(negedge clk_24mhz);
    rst_n = 1'b0;
    tick(3);
    reset_checks("rst_pulse");
    rst_n = 1'b1;
    tick(3);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    SCE   = 1'b1;
    RST   = 1'b1;
    D_C   = 1'b0;
    MOSI  = 1'b0;
    SCLK  = 1'b0;
    tick(5);
    reset_checks("reset");
    rst_n = 1'b1;
    tick(5);

    // Single data byte
    dat(8'hA5);
    drain("t1_drain");
    check("t1_frame_err", {31'd0, frame_err}, 0);

    // Window 2..3 x 5..6 with full-window wrap back to (2,5)
    cmd(8'h2A); dat(8'h00); dat(8'h02); dat(8'h00); dat(8'h03);
    cmd(8'h2B); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h06);
    exp_pix(2, 5, 16'hF800);
    exp_pix(3, 5, 16'h07E0);
    exp_pix(2, 6, 16'h001F);
    exp_pix(3, 6, 16'hFFFF);
    exp_pix(2, 5, 16'h1234);
    cmd(8'h2C);
    dat(8'hF8); dat(8'h00); dat(8'h07); dat(8'hE0); dat(8'h00);
    dat(8'h1F); dat(8'hFF); dat(8'hFF); dat(8'h12); dat(8'h34);
    drain("t2_drain");

    // Partial byte sets frame_err; next byte still good; SWRESET clears it
    send_bits(1'b1, 8'hB0, 5);
    tick(4);
    check("t3_frame_err_set", {31'd0, frame_err}, 1);
    dat(8'h3C);
    drain("t3_after_partial");
    check("t3_frame_err_sticky", {31'd0, frame_err}, 1);
    cmd(8'h01);
    drain("t3_swreset");
    check("t3_frame_err_clr", {31'd0, frame_err}, 0);

    // Default window raster: last pixel (W-1,H-1), then wrap to (0,0)
    cmd(8'h2C);
    for (int i = 0; i <= W * H; i++) exp_pix(i % W, (i / W) % H, {8'(i), 8'(i + 1)});
    for (int i = 0; i <= W * H; i++) begin
      dat(8'(i));
      dat(8'(i + 1));
    end
    drain("t4_raster");

    // Truncated CASET leaves window alone; RST aborts RAMWR and restores defaults
    cmd(8'h2A); dat(8'h00); dat(8'h10); dat(8'h00);
    cmd(8'h2C);
    exp_pix(0, 0, 16'hABCD);
    dat(8'hAB); dat(8'hCD);
    cmd(8'h2A); dat(8'h00); dat(8'h01); dat(8'h00); dat(8'h02);
    cmd(8'h2C);
    exp_pix(1, 0, 16'h1122);
    dat(8'h11); dat(8'h22);
    dat(8'h33);
    drain("t5_pre_rst");
    @(negedge clk_24mhz);
    RST = 1'b0;
    tick(10);
    RST = 1'b1;
    tick(10);
    dat(8'h44);
    drain("t5_post_rst");
    check("t5_frame_err", {31'd0, frame_err}, 0);
    cmd(8'h2C);
    for (int x = 0; x < W; x++) exp_pix(x, 0, {8'(x), 8'h5A});
    exp_pix(0, 1, 16'hEE5A);
    for (int x = 0; x < W; x++) begin
      dat(8'(x));
      dat(8'h5A);
    end
    dat(8'hEE); dat(8'h5A);
    drain("t5_defaults");

    // rst_n in the middle of a byte drops the bits already shifted
    @(negedge clk_24mhz);
    SCE = 1'b0;
    D_C = 1'b1;
    tick(4);
    for (int i = 0; i < 4; i++) clock_bit(1'b1);
    pulse_rst_n();
    for (int i = 0; i < 4; i++) clock_bit(1'b0);
    tick(4);
    SCE = 1'b1;
    tick(6);
    check("t6_discard_frame_err", {31'd0, frame_err}, 1);
    cmd(8'h01);
    drain("t6_drain");
    check("t6_frame_err_clr", {31'd0, frame_err}, 0);

`ifdef ST7735_SINK_STATS_EN
    pulse_rst_n();
    cmd(8'h00); cmd(8'h00); cmd(8'h2C);
    exp_pix(0, 0, 16'h0102);
    exp_pix(1, 0, 16'h0304);
    exp_pix(2, 0, 16'h0506);
    exp_pix(3, 0, 16'h0708);
    for (int i = 1; i <= 8; i++) dat(8'(i));
    drain("t7_drain");
    check("t7_stat_cmd", {16'd0, stat_cmd_cnt}, 3);
    check("t7_stat_pix", {8'd0, stat_pix_cnt}, 4);
    pulse_rst_n();
    check("t7_stat_cmd_rst", {16'd0, stat_cmd_cnt}, 0);
    check("t7_stat_pix_rst", {8'd0, stat_pix_cnt}, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
